and_sweep_ctrl_amisha: RTL and testbench
========================================

// Module: and_sweep_ctrl_amisha
// PURPOSE
//  Sequencer for the 3-input AND datapath (a,b,c -> y). On start, it drives all 8 input
//  vectors in binary order 000..111 as {a,b,c}, holding each for HOLD_CYCLES clocks.
//  It samples y on the last hold cycle, compares y against &{a,b,c}, and reports an
//  error count, the first failing vector and pass/done status.
//  Sits between a control source (switches/host FSM) and the combinational AND unit.
// PARAMETERS
//  HOLD_CYCLES  4  clocks each vector is held; legal range 2..255; y sampled on last hold cycle
//  CNT_W        8  width of hold counter; must satisfy 2**CNT_W > HOLD_CYCLES
// PORTS
//  clk_amisha         in   1  rising-edge clock
//  reset_amisha       in   1  synchronous, active-high reset
//  start_amisha       in   1  level; sampled only in IDLE; 1 = begin sweep
//  abort_amisha       in   1  1 = terminate sweep, return to IDLE, no done pulse
//  y_amisha           in   1  output of AND unit under control
//  a_amisha           out  1  AND input a (vector bit 2), registered
//  b_amisha           out  1  AND input b (vector bit 1), registered
//  c_amisha           out  1  AND input c (vector bit 0), registered
//  busy_amisha        out  1  1 while in APPLY
//  done_amisha        out  1  single-cycle pulse in FINISH
//  pass_amisha        out  1  1 = last completed sweep had zero mismatches
//  err_count_amisha   out  4  mismatches in current/last sweep, 0..8
//  fail_valid_amisha  out  1  1 = at least one mismatch recorded
//  fail_vec_amisha    out  3  {a,b,c} of first mismatch; 0 when fail_valid=0
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, vec=0, hold=0. Reset dominates start/abort,
//    including mid-sweep.
//  - States: IDLE, APPLY, FINISH. All outputs are registered.
//  - IDLE: a/b/c=0, busy=0. If start=1 (and abort=0) at edge k: enter APPLY; vec=0; hold=0;
//    clear err_count, fail_valid, fail_vec, pass. Results hold until then.
//  - APPLY: busy=1; {a,b,c}=vec; hold increments each clock.
//    On the edge where hold==HOLD_CYCLES-1:
//      * compare y with (vec==3'b111);
//      * on mismatch, err_count+1; if fail_valid=0, capture fail_vec=vec and set fail_valid=1;
//      * if vec==7, go to FINISH; else vec+1, hold=0.
//  - Total APPLY time is exactly 8*HOLD_CYCLES clocks; no wrap of vec past 7.
//  - FINISH (1 cycle): done=1, busy=0, a/b/c=0. pass is registered on the FINISH entry edge
//    from the final err_count, including any last-sample mismatch. Next state is IDLE
//    unconditionally. start during FINISH is ignored; it must be re-sampled in IDLE.
//  - done rises at edge k+8*HOLD_CYCLES and falls one clock later.
//  - abort=1 in APPLY: next state IDLE, a/b/c=0, no done; err_count/fail_* keep partial
//    values; pass stays 0. abort in IDLE/FINISH: no effect, except that it blocks start in IDLE.
//  - start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
//  - Simultaneous start+abort in IDLE: abort wins, stay IDLE.
//  - err_count saturates at 8; this is reachable only if every vector fails.
// STRUCTURE
//  - Package and_sweep_pkg_amisha: state encoding localparams (IDLE=2'd0, APPLY=2'd1,
//    FINISH=2'd2), NUM_VECS=8, LAST_VEC=3'd7.
//  - Single module, no sub-module. Hold counter, vector counter and compare are inline;
//    the AND unit is instantiated by the parent, not in here.
// TESTING
//  - Good AND model, HOLD_CYCLES=4, start pulse at edge k -> a/b/c steps 000..111 every
//    4 clocks; done pulse at k+32; pass=1, err_count=0, fail_valid=0.
//  - Faulty model y stuck-at-1 -> err_count=7, fail_vec=3'b000, pass=0, done pulses once.
//  - Faulty model y=a&b (ignores c) -> err_count=1, fail_vec=3'b110, pass=0.
//  - abort asserted on 10th APPLY clock -> IDLE next edge, a/b/c=0, no done,
//    err_count keeps its partial value; next start clears it.
//  - reset_amisha pulsed mid-sweep, with start also high -> all outputs 0 next edge;
//    start held afterwards -> fresh sweep from 000.
//  - start held high across FINISH -> exactly one IDLE cycle, then a new sweep; start+abort
//    together in IDLE -> no sweep.

Source files
------------

// File: rtl/and_sweep_pkg_amisha.sv
// Shared definitions for the 3-input AND sweep sequencer: state encoding,
// vector bounds and the saturating mismatch counter helper.
package and_sweep_pkg_amisha;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] APPLY  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam int         NUM_VECS = 8;
    localparam logic [2:0] LAST_VEC = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_APPLY  = APPLY,
        ST_FINISH = FINISH
    } sweep_state_e;

    // Mismatch count never exceeds the number of vectors in one sweep.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        logic [3:0] res;
        if (cnt >= 4'(NUM_VECS)) begin
            res = cnt;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/and_sweep_ctrl_amisha.sv
// Drives all eight {a,b,c} vectors into an external AND unit, samples y on the
// last hold cycle of each vector and reports mismatch count, first failure and pass.
module and_sweep_ctrl_amisha
    import and_sweep_pkg_amisha::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk_amisha,
    input  logic       reset_amisha,
    input  logic       start_amisha,
    input  logic       abort_amisha,
    input  logic       y_amisha,
    output logic       a_amisha,
    output logic       b_amisha,
    output logic       c_amisha,
    output logic       busy_amisha,
    output logic       done_amisha,
    output logic       pass_amisha,
    output logic [3:0] err_count_amisha,
    output logic       fail_valid_amisha,
    output logic [2:0] fail_vec_amisha
);

    sweep_state_e     state_r, state_nxt_s;
    logic [2:0]       vec_r, vec_nxt_s;
    logic [CNT_W-1:0] hold_r, hold_nxt_s;
    logic [2:0]       abc_r, abc_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             pass_r, pass_nxt_s;
    logic [3:0]       err_r, err_nxt_s;
    logic             fv_valid_r, fv_valid_nxt_s;
    logic [2:0]       fv_r, fv_nxt_s;
    logic             hold_last_s;
    logic             mismatch_s;

    assign hold_last_s = (hold_r == CNT_W'(HOLD_CYCLES - 1));
    assign mismatch_s  = (y_amisha != (vec_r == LAST_VEC));

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        vec_nxt_s      = vec_r;
        hold_nxt_s     = hold_r;
        abc_nxt_s      = abc_r;
        busy_nxt_s     = busy_r;
        done_nxt_s     = 1'b0;
        pass_nxt_s     = pass_r;
        err_nxt_s      = err_r;
        fv_valid_nxt_s = fv_valid_r;
        fv_nxt_s       = fv_r;
        case (state_r)
            ST_IDLE: begin
                abc_nxt_s  = 3'd0;
                busy_nxt_s = 1'b0;
                // abort blocks start so a stuck abort line can never launch a sweep
                if (start_amisha && !abort_amisha) begin
                    state_nxt_s    = ST_APPLY;
                    vec_nxt_s      = 3'd0;
                    hold_nxt_s     = {CNT_W{1'b0}};
                    abc_nxt_s      = 3'd0;
                    busy_nxt_s     = 1'b1;
                    pass_nxt_s     = 1'b0;
                    err_nxt_s      = 4'd0;
                    fv_valid_nxt_s = 1'b0;
                    fv_nxt_s       = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (abort_amisha) begin
                    state_nxt_s = ST_IDLE;
                    abc_nxt_s   = 3'd0;
                    busy_nxt_s  = 1'b0;
                    hold_nxt_s  = {CNT_W{1'b0}};
                end else if (hold_last_s) begin
                    if (mismatch_s) begin
                        err_nxt_s = sat_inc(err_r);
                        if (!fv_valid_r) begin
                            fv_valid_nxt_s = 1'b1;
                            fv_nxt_s       = vec_r;
                        end else begin
                            fv_nxt_s = fv_r;
                        end
                    end else begin
                        err_nxt_s = err_r;
                    end
                    hold_nxt_s = {CNT_W{1'b0}};
                    // pass must see the count including this final sample
                    if (vec_r == LAST_VEC) begin
                        state_nxt_s = ST_FINISH;
                        abc_nxt_s   = 3'd0;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = (err_nxt_s == 4'd0);
                    end else begin
                        vec_nxt_s = vec_r + 3'd1;
                        abc_nxt_s = vec_r + 3'd1;
                    end
                end else begin
                    hold_nxt_s = hold_r + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
                abc_nxt_s   = 3'd0;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                vec_nxt_s   = 3'd0;
                hold_nxt_s  = {CNT_W{1'b0}};
                abc_nxt_s   = 3'd0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_r    <= ST_IDLE;
            vec_r      <= 3'd0;
            hold_r     <= {CNT_W{1'b0}};
            abc_r      <= 3'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_r      <= 4'd0;
            fv_valid_r <= 1'b0;
            fv_r       <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            vec_r      <= vec_nxt_s;
            hold_r     <= hold_nxt_s;
            abc_r      <= abc_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            pass_r     <= pass_nxt_s;
            err_r      <= err_nxt_s;
            fv_valid_r <= fv_valid_nxt_s;
            fv_r       <= fv_nxt_s;
        end
    end

    assign a_amisha          = abc_r[2];
    assign b_amisha          = abc_r[1];
    assign c_amisha          = abc_r[0];
    assign busy_amisha       = busy_r;
    assign done_amisha       = done_r;
    assign pass_amisha       = pass_r;
    assign err_count_amisha  = err_r;
    assign fail_valid_amisha = fv_valid_r;
    assign fail_vec_amisha   = fv_r;

endmodule

// File: tb/tb_and_sweep_ctrl_amisha.sv
// Randomized scoreboard bench for the AND sweep sequencer; the AND unit is a
// truth-table model so good and faulty units can be emulated.
module tb_and_sweep_ctrl_amisha;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset, start, abort, y;
    logic       a, b, c, busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] fail_vec;
    logic [7:0] tt;

    typedef struct {
        logic [3:0] err;
        logic       fv_valid;
        logic [2:0] fv;
        logic       pass;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   busy_n  = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;
    bit   mon_en = 1'b0;

    and_sweep_ctrl_amisha #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk_amisha(clk), .reset_amisha(reset), .start_amisha(start),
        .abort_amisha(abort), .y_amisha(y), .a_amisha(a), .b_amisha(b),
        .c_amisha(c), .busy_amisha(busy), .done_amisha(done),
        .pass_amisha(pass), .err_count_amisha(err_count),
        .fail_valid_amisha(fail_valid), .fail_vec_amisha(fail_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always_comb y = tt[{a, b, c}];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    // Expected result after the first nvec vectors have been judged.
    function automatic exp_t model(input logic [7:0] t, input int nvec, input int dc);
        exp_t e;
        e.err = 4'd0; e.fv_valid = 1'b0; e.fv = 3'd0; e.done_cyc = dc;
        for (int v = 0; v < nvec; v++) begin
            if (t[v] != (v == 7)) begin
                e.err = e.err + 4'd1;
                if (!e.fv_valid) begin
                    e.fv_valid = 1'b1;
                    e.fv = 3'(v);
                end
            end
        end
        e.pass = (nvec == 8) && (e.err == 4'd0);
        return e;
    endfunction

    // Monitor: vector sequence while busy, and result scoreboard on done.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("abc", {29'd0, a, b, c}, busy ? 32'(busy_n / H) : 32'd0);
            if (busy) begin
                chk("busy_len", 32'(busy_n < 8 * H), 32'd1);
                busy_n++;
            end else begin
                busy_n = 0;
            end
            if (done) begin
                done_cnt++;
                chk("done_width", {31'd0, done_prev}, 32'd0);
                chk("busy_in_finish", {31'd0, busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cyc", cyc, e.done_cyc);
                    chk("err_count", {28'd0, err_count}, {28'd0, e.err});
                    chk("fail_valid", {31'd0, fail_valid}, {31'd0, e.fv_valid});
                    chk("fail_vec", {29'd0, fail_vec}, {29'd0, e.fv});
                    chk("pass", {31'd0, pass}, {31'd0, e.pass});
                end
            end
            done_prev = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (done_cnt < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_cleared();
        chk("clr_busy", {31'd0, busy}, 32'd1);
        chk("clr_err", {28'd0, err_count}, 32'd0);
        chk("clr_fv_valid", {31'd0, fail_valid}, 32'd0);
        chk("clr_fv", {29'd0, fail_vec}, 32'd0);
        chk("clr_pass", {31'd0, pass}, 32'd0);
    endtask

    task automatic run_sweep(input logic [7:0] t);
        tt = t;
        exp_q.push_back(model(t, 8, cyc + 1 + 8 * H));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cleared();
        wait_done(done_cnt + 1, 8 * H + 10);
        tick(2);
    endtask

    task automatic check_all_zero(input string nm);
        chk(nm, {18'd0, a, b, c, busy, done, pass, err_count, fail_valid, fail_vec}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   dc;
        reset = 1'b1; start = 1'b0; abort = 1'b0; tt = 8'h80;
        tick(3);
        check_all_zero("reset_state");
        reset = 1'b0;
        tick(1);
        check_all_zero("idle_after_reset");
        mon_en = 1'b1;

        // Good unit, stuck-at-1, y=a&b, and every vector failing.
        run_sweep(8'h80);
        run_sweep(8'hFF);
        run_sweep(8'hC0);
        run_sweep(8'h7F);
        repeat (5) run_sweep(8'($urandom));

        // Abort sampled on the 10th APPLY clock keeps partial results.
        tt = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick(9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        e = model(tt, 10 / H, 0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_abc", {29'd0, a, b, c}, 32'd0);
        chk("abort_err", {28'd0, err_count}, {28'd0, e.err});
        chk("abort_fv_valid", {31'd0, fail_valid}, {31'd0, e.fv_valid});
        chk("abort_fv", {29'd0, fail_vec}, {29'd0, e.fv});
        chk("abort_pass", {31'd0, pass}, 32'd0);
        dc = done_cnt;
        tick(40);
        chk("abort_no_done", done_cnt, dc);
        run_sweep(8'h80);

        // Reset mid-sweep with start high, then start held across FINISH.
        tt = 8'hFF;
        start = 1'b1;
        tick(13);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midsweep_reset");
        reset = 1'b0;
        exp_q.push_back(model(tt, 8, cyc + 1 + 8 * H));
        exp_q.push_back(model(tt, 8, cyc + 1 + 16 * H + 2));
        wait_done(done_cnt + 1, 8 * H + 10);
        wait_done(done_cnt + 1, 8 * H + 10);
        start = 1'b0;
        tick(4);
        chk("no_third_sweep", {31'd0, busy}, 32'd0);

        // start together with abort in IDLE never launches a sweep.
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("start_abort_idle", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;
        abort = 1'b0;
        tick(3);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
